// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem request/response, 2-entry queue to decode.
// Optional macro FETCH_MISALIGN_EN: misaligned redirect halts fetch.
// Ports:
//   clock, reset_n        : clock, async active-low reset
//   imem_req_*            : valid/ready word read request (addr)
//   imem_resp_*           : read data return (valid, data)
//   redirect_valid/_pc    : taken branch/jump target
//   instr_valid/instr/_pc : queue head to decode, instr_ready pops
//   misalign_err          : one-cycle pulse on misaligned redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign_err
);

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [1:0] {
    BOOT, ISSUE, WAIT, HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    BOOT, ISSUE, WAIT
  } state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic [1:0]  count;
  logic        outstanding;
  logic        req_epoch;
  logic        epoch;

  logic        req_fire;
  logic        resp_hit;
  logic        push;
  logic        pop;
  logic        keep_wait;
  logic [31:0] target;

  assign imem_req_valid = (state == ISSUE) &&
                          ((count + {1'b0, outstanding}) < 2'd2);
  assign imem_req_addr  = pc;
  assign instr_valid    = (count != 2'd0);
  assign instr          = instr_valid ? q_instr[0] : NOP_INSTR;
  assign instr_pc       = instr_valid ? q_pc[0] : 32'h0;

  assign req_fire = imem_req_valid & imem_req_ready;
  // A response with nothing in flight is noise and ignored.
  assign resp_hit = imem_resp_valid & outstanding;
  assign pop      = instr_valid & instr_ready;
  assign push     = resp_hit & (state == WAIT) &
                    (req_epoch == epoch) & ~redirect_valid;
  // A request accepted during a redirect still returns a stale word.
  assign keep_wait = req_fire | (outstanding & ~resp_hit);

`ifdef FETCH_MISALIGN_EN
  assign target = redirect_pc;
`else
  logic unused_lsb;
  assign target     = {redirect_pc[31:2], 2'b00};
  assign unused_lsb = ^redirect_pc[1:0];
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      q_instr[0]  <= NOP_INSTR;
      q_instr[1]  <= NOP_INSTR;
      q_pc[0]     <= 32'h0;
      q_pc[1]     <= 32'h0;
      count       <= 2'd0;
      outstanding <= 1'b0;
      req_epoch   <= 1'b0;
      epoch       <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      misalign_err <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_EN
      misalign_err <= 1'b0;
`endif
      if (req_fire) begin
        outstanding <= 1'b1;
        req_epoch   <= epoch;
        req_pc      <= pc;
      end else if (resp_hit) begin
        outstanding <= 1'b0;
      end

      if (redirect_valid) begin
        count <= 2'd0;
        epoch <= ~epoch;
`ifdef FETCH_MISALIGN_EN
        if (|redirect_pc[1:0]) begin
          state        <= HALT;
          misalign_err <= 1'b1;
        end else begin
          pc    <= target;
          state <= keep_wait ? WAIT : ISSUE;
        end
`else
        pc    <= target;
        state <= keep_wait ? WAIT : ISSUE;
`endif
      end else begin
        case ({push, pop})
          2'b10: begin
            q_instr[count[0]] <= imem_resp_data;
            q_pc[count[0]]    <= req_pc;
            count             <= count + 2'd1;
          end
          2'b01: begin
            q_instr[0] <= q_instr[1];
            q_pc[0]    <= q_pc[1];
            count      <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              q_instr[0] <= imem_resp_data;
              q_pc[0]    <= req_pc;
            end else begin
              q_instr[0] <= q_instr[1];
              q_pc[0]    <= q_pc[1];
              q_instr[1] <= imem_resp_data;
              q_pc[1]    <= req_pc;
            end
          end
          default: ;
        endcase

        unique case (state)
          BOOT:  state <= ISSUE;
          ISSUE: begin
            if (req_fire) begin
              pc    <= pc + 32'd4;
              state <= WAIT;
            end
          end
          WAIT: begin
            if (resp_hit) state <= ISSUE;
          end
`ifdef FETCH_MISALIGN_EN
          HALT: ;
`endif
          default: state <= BOOT;
        endcase
      end
    end
  end

endmodule
